btn_press_sync: RTL and testbench

Consumes the periodic single-cycle `slowen` strobe produced by the `DIV256` divider and turns the two raw, bouncing player pushbuttons into clean, debounced levels and single-cycle press pulses for the tug-of-war game logic. It is the receiving end of the slow-enable path: it synchronises the buttons at full clock rate, samples them only on `slowen` ticks, and reports each press exactly once. Both press pulses are also checked for a same-cycle tie.

---
 rtl/btn_press_sync_if.sv | 21 ++
 rtl/btn_press_sync.sv | 129 ++++++++++++
 tb/tb_btn_press_sync.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_press_sync_if.sv
// Button debouncer bundle: sample strobe and raw buttons in, debounced levels and press pulses out.
interface btn_press_sync_if;
  logic slowen;
  logic btn_l_raw;
  logic btn_r_raw;
  logic level_l;
  logic level_r;
  logic press_l;
  logic press_r;
  logic tie;

  modport master (
    output slowen, btn_l_raw, btn_r_raw,
    input  level_l, level_r, press_l, press_r, tie
  );

  modport slave (
    input  slowen, btn_l_raw, btn_r_raw,
    output level_l, level_r, press_l, press_r, tie
  );
endinterface

// File: rtl/btn_press_sync.sv
// Two-channel pushbutton debouncer: 2-flop synchronisers, per-channel 4-state qualifier
// sampled on the slow strobe, registered levels, press pulses and a same-cycle tie flag.
module btn_press_sync #(
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  btn_press_sync_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RISING  = 2'd1,
    HELD    = 2'd2,
    FALLING = 2'd3
  } state_e;

  typedef struct packed {
    state_e     st;
    logic [2:0] cnt;
    logic       press;
  } ch_t;

  localparam logic [2:0] TARGET = 3'(STABLE_SAMPLES);

  logic [1:0] meta_q, sync_q;
  ch_t        l_q, l_d, r_q, r_d;
  logic [1:0] level_q, level_d;
  logic       tie_q, tie_d;

  // One sample step of a channel; any disagreeing sample mid-count snaps back to the stable state.
  function automatic ch_t ch_next(input ch_t cur, input logic s);
    ch_t nx;
    nx       = cur;
    nx.press = 1'b0;
    unique case (cur.st)
      IDLE: begin
        if (s) begin
          if (TARGET == 3'd1) begin
            nx.st    = HELD;
            nx.cnt   = '0;
            nx.press = 1'b1;
          end else begin
            nx.st  = RISING;
            nx.cnt = 3'd1;
          end
        end
      end
      RISING: begin
        if (!s) begin
          nx.st  = IDLE;
          nx.cnt = '0;
        end else if (cur.cnt + 3'd1 == TARGET) begin
          nx.st    = HELD;
          nx.cnt   = '0;
          nx.press = 1'b1;
        end else begin
          nx.cnt = cur.cnt + 3'd1;
        end
      end
      HELD: begin
        if (!s) begin
          if (TARGET == 3'd1) begin
            nx.st  = IDLE;
            nx.cnt = '0;
          end else begin
            nx.st  = FALLING;
            nx.cnt = 3'd1;
          end
        end
      end
      FALLING: begin
        if (s) begin
          nx.st  = HELD;
          nx.cnt = '0;
        end else if (cur.cnt + 3'd1 == TARGET) begin
          nx.st  = IDLE;
          nx.cnt = '0;
        end else begin
          nx.cnt = cur.cnt + 3'd1;
        end
      end
      default: begin
        nx.st  = IDLE;
        nx.cnt = '0;
      end
    endcase
    return nx;
  endfunction

  always_comb begin
    l_d       = l_q;
    r_d       = r_q;
    l_d.press = 1'b0;
    r_d.press = 1'b0;
    if (bus.slowen) begin
      l_d = ch_next(l_q, sync_q[0]);
      r_d = ch_next(r_q, sync_q[1]);
    end
    level_d = {(r_d.st == HELD) || (r_d.st == FALLING),
               (l_d.st == HELD) || (l_d.st == FALLING)};
    tie_d   = l_d.press & r_d.press;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= '0;
      sync_q  <= '0;
      l_q     <= '{st: IDLE, cnt: '0, press: 1'b0};
      r_q     <= '{st: IDLE, cnt: '0, press: 1'b0};
      level_q <= '0;
      tie_q   <= 1'b0;
    end else begin
      meta_q  <= {bus.btn_r_raw, bus.btn_l_raw};
      sync_q  <= meta_q;
      l_q     <= l_d;
      r_q     <= r_d;
      level_q <= level_d;
      tie_q   <= tie_d;
    end
  end

  assign bus.level_l = level_q[0];
  assign bus.level_r = level_q[1];
  assign bus.press_l = l_q.press;
  assign bus.press_r = r_q.press;
  assign bus.tie     = tie_q;

endmodule

// File: tb/tb_btn_press_sync.sv
// Self-checking bench for btn_press_sync: two instances (STABLE_SAMPLES 4 and 1) share stimulus
// and are compared every cycle against a run-length reference model.
module tb_btn_press_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sl  = 1'b0;
  logic bl  = 1'b0;
  logic br  = 1'b0;

  always #5 clk = ~clk;

  btn_press_sync_if ifa ();
  btn_press_sync_if ifb ();

  assign ifa.slowen    = sl;
  assign ifa.btn_l_raw = bl;
  assign ifa.btn_r_raw = br;
  assign ifb.slowen    = sl;
  assign ifb.btn_l_raw = bl;
  assign ifb.btn_r_raw = br;

  btn_press_sync #(.STABLE_SAMPLES(4)) dut4 (.clk(clk), .rst(rst), .bus(ifa));
  btn_press_sync #(.STABLE_SAMPLES(1)) dut1 (.clk(clk), .rst(rst), .bus(ifb));

  logic [4:0] obs4, obs1;
  assign obs4 = {ifa.level_l, ifa.level_r, ifa.press_l, ifa.press_r, ifa.tie};
  assign obs1 = {ifb.level_l, ifb.level_r, ifb.press_l, ifb.press_r, ifb.tie};

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: debounced level plus length of the current disagreeing run per channel.
  int ssv [2] = '{4, 1};
  bit m_lvl [2][2];
  bit m_prs [2][2];
  int m_run [2][2];
  bit m_tie [2];
  bit hq [2][$];

  function automatic logic [4:0] expv(input int d);
    return {m_lvl[d][0], m_lvl[d][1], m_prs[d][0], m_prs[d][1], m_tie[d]};
  endfunction

  // Advance one clock edge and update the model from the inputs seen at that edge.
  task automatic cyc();
    bit s [2];
    bit raw [2];
    @(posedge clk);
    raw[0] = bl;
    raw[1] = br;
    for (int ch = 0; ch < 2; ch++) begin
      if (rst) begin
        hq[ch].delete();
        hq[ch].push_back(1'b0);
        hq[ch].push_back(1'b0);
        s[ch] = 1'b0;
      end else begin
        if (hq[ch].size() < 2) begin
          hq[ch].delete();
          hq[ch].push_back(1'b0);
          hq[ch].push_back(1'b0);
        end
        s[ch] = hq[ch].pop_front();
        hq[ch].push_back(raw[ch]);
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_prs[d][ch] = 1'b0;
        if (rst) begin
          m_lvl[d][ch] = 1'b0;
          m_run[d][ch] = 0;
        end else if (sl) begin
          if (s[ch] != m_lvl[d][ch]) begin
            m_run[d][ch]++;
            if (m_run[d][ch] == ssv[d]) begin
              m_lvl[d][ch] = s[ch];
              m_run[d][ch] = 0;
              m_prs[d][ch] = s[ch];
            end
          end else begin
            m_run[d][ch] = 0;
          end
        end
      end
      m_tie[d] = m_prs[d][0] & m_prs[d][1];
    end
    #1;
  endtask

  task automatic test_reset();
    int ties = 0;
    int ties1 = 0;
    rst = 1'b1; bl = 1'b1; br = 1'b1; sl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_cmp++;
      if (obs4 !== 5'b0) begin
        n_bad++; $display("FAIL reset_hold ss4 cyc=%0d got=%b want=00000", i, obs4);
      end
      n_cmp++;
      if (obs1 !== 5'b0) begin
        n_bad++; $display("FAIL reset_hold ss1 cyc=%0d got=%b want=00000", i, obs1);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sl = (i % 8 == 7);
      cyc();
      ties += ifa.tie;
      ties1 += ifb.tie;
      n_cmp++;
      if (obs4 !== expv(0)) begin
        n_bad++; $display("FAIL reset_requal ss4 cyc=%0d got=%b want=%b", i, obs4, expv(0));
      end
      n_cmp++;
      if (obs1 !== expv(1)) begin
        n_bad++; $display("FAIL reset_requal ss1 cyc=%0d got=%b want=%b", i, obs1, expv(1));
      end
      if (i == 31) begin
        n_cmp++;
        if (obs4 !== 5'b11111) begin
          n_bad++; $display("FAIL reset_tick4_tie ss4 got=%b want=11111", obs4);
        end
      end
    end
    n_cmp++;
    if (ties != 1 || ties1 != 1) begin
      n_bad++; $display("FAIL reset_tie_count got ss4=%0d ss1=%0d want 1/1", ties, ties1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sl = 1'b0; bl = 1'b0; br = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  task automatic test_clean_press();
    int pl = 0;
    int pr = 0;
    do_reset();
    bl = 1'b1;
    for (int i = 0; i < 5 * 256; i++) begin
      sl = (i % 256 == 255);
      cyc();
      pl += ifa.press_l;
      pr += ifa.press_r;
      n_cmp++;
      if (obs4 !== expv(0) || obs1 !== expv(1)) begin
        n_bad++; $display("FAIL clean_press cyc=%0d got=%b/%b want=%b/%b", i, obs4, obs1, expv(0), expv(1));
      end
    end
    n_cmp++;
    if (pl != 1 || pr != 0 || ifa.level_l !== 1'b1) begin
      n_bad++; $display("FAIL clean_press_summary got pl=%0d pr=%0d lvl=%b want 1 0 1", pl, pr, ifa.level_l);
    end
  endtask

  task automatic test_bounce();
    int early = 0;
    int late = 0;
    do_reset();
    for (int t = 1; t <= 8; t++) begin
      bl = (t != 4);
      for (int i = 0; i < 8; i++) begin
        sl = (i == 7);
        cyc();
        if (t < 8) early += ifa.press_l;
        else late += ifa.press_l;
        n_cmp++;
        if (obs4 !== expv(0) || obs1 !== expv(1)) begin
          n_bad++; $display("FAIL bounce t=%0d cyc=%0d got=%b/%b want=%b/%b", t, i, obs4, obs1, expv(0), expv(1));
        end
      end
    end
    n_cmp++;
    if (early != 0 || late != 1) begin
      n_bad++; $display("FAIL bounce_pulses got early=%0d late=%0d want 0 1", early, late);
    end
  endtask

  task automatic test_release();
    int pl = 0;
    logic lvl_mid;
    for (int t = 1; t <= 9; t++) begin
      bl = (t == 4 || t == 5);
      for (int i = 0; i < 8; i++) begin
        sl = (i == 7);
        cyc();
        pl += ifa.press_l;
        n_cmp++;
        if (obs4 !== expv(0) || obs1 !== expv(1)) begin
          n_bad++; $display("FAIL release t=%0d cyc=%0d got=%b/%b want=%b/%b", t, i, obs4, obs1, expv(0), expv(1));
        end
      end
      if (t == 8) lvl_mid = ifa.level_l;
    end
    n_cmp++;
    if (lvl_mid !== 1'b1 || ifa.level_l !== 1'b0 || pl != 0) begin
      n_bad++; $display("FAIL release_summary got lvl8=%b lvl9=%b pulses=%0d want 1 0 0", lvl_mid, ifa.level_l, pl);
    end
  endtask

  task automatic test_offset();
    int pl = 0;
    int pr = 0;
    int ties = 0;
    do_reset();
    for (int t = 1; t <= 6; t++) begin
      bl = 1'b1;
      br = (t >= 2);
      for (int i = 0; i < 8; i++) begin
        sl = (i == 7);
        cyc();
        pl += ifa.press_l; pr += ifa.press_r; ties += ifa.tie;
        n_cmp++;
        if (obs4 !== expv(0) || obs1 !== expv(1)) begin
          n_bad++; $display("FAIL offset t=%0d cyc=%0d got=%b/%b want=%b/%b", t, i, obs4, obs1, expv(0), expv(1));
        end
      end
    end
    n_cmp++;
    if (pl != 1 || pr != 1 || ties != 0) begin
      n_bad++; $display("FAIL offset_summary got pl=%0d pr=%0d tie=%0d want 1 1 0", pl, pr, ties);
    end
  endtask

  task automatic test_mid_reset();
    int p_before = 0;
    int p_after = 0;
    int p1_first = 0;
    do_reset();
    bl = 1'b1;
    for (int i = 0; i < 24; i++) begin
      sl = (i % 8 == 7);
      cyc();
      p_before += ifa.press_l;
    end
    rst = 1'b1; sl = 1'b1;
    cyc(); cyc();
    n_cmp++;
    if (obs4 !== 5'b0 || obs1 !== 5'b0 || p_before != 0) begin
      n_bad++; $display("FAIL mid_reset got=%b/%b early_pulses=%0d want 00000/00000 0", obs4, obs1, p_before);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sl = (i % 8 == 7);
      cyc();
      p_after += ifa.press_l;
      if (i < 8) p1_first += ifb.press_l;
      n_cmp++;
      if (obs4 !== expv(0) || obs1 !== expv(1)) begin
        n_bad++; $display("FAIL mid_reset_requal cyc=%0d got=%b/%b want=%b/%b", i, obs4, obs1, expv(0), expv(1));
      end
    end
    n_cmp++;
    if (p_after != 1 || p1_first != 1) begin
      n_bad++; $display("FAIL mid_reset_pulses got ss4=%0d ss1_first=%0d want 1 1", p_after, p1_first);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(39) == 0) bl = ~bl;
      if ($urandom_range(39) == 0) br = ~br;
      sl  = ($urandom_range(3) == 0);
      rst = ($urandom_range(499) == 0);
      cyc();
      n_cmp++;
      if (obs4 !== expv(0)) begin
        n_bad++; $display("FAIL random ss4 cyc=%0d got=%b want=%b", i, obs4, expv(0));
      end
      n_cmp++;
      if (obs1 !== expv(1)) begin
        n_bad++; $display("FAIL random ss1 cyc=%0d got=%b want=%b", i, obs1, expv(1));
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release();
    test_offset();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
